calc_input_controller: RTL and testbench
========================================

Name: calc_input_controller

Overview:
- Front-end controller that drives the combinational adder_subtractor from board inputs and captures its result.
- Debounces two raw pushbuttons, enter and op.
- Enter presses latch the 4-bit switch value into A, then into B, then advance to the result display.
- Op presses toggle add/subtract. The block sits between the board I/O and adder_subtractor and feeds the display logic.

Parameters:
- WIDTH, 4, operand and result width in bits.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a debounced level changes. Board builds override this to about 250000.
- CNT_W, 18, debounce counter width. It must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sw  input  WIDTH  raw switch value (quasi-static).
- btn_enter  input  1  raw enter pushbutton (asynchronous, bouncy).
- btn_op  input  1  raw op pushbutton (asynchronous, bouncy).
- A  output  WIDTH  operand A to adder_subtractor.
- B  output  WIDTH  operand B to adder_subtractor.
- button  output  1  operation select to adder_subtractor: 0 = add, 1 = subtract.
- R  input  WIDTH  result from adder_subtractor (combinational from A, B, button).
- result  output  WIDTH  captured result.
- result_valid  output  1  high while result holds the value for the current A, B and button.
- state  output  2  current FSM state, for LEDs and debug.

Behaviour:
- Reset (asynchronous, any state): A=0, B=0, button=0, result=0, result_valid=0, state=LOAD_A. Debouncers clear their sync flops, counters and debounced levels to 0.
- Debouncer, per button:
  - 2-flop synchroniser feeds the comparison.
  - Counter clears whenever the synchronised value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced level takes the synchronised value and the counter clears.
  - The registered rise pulse is high for exactly one cycle, on the cycle after the debounced level goes 0->1.
  - Press-to-pulse latency is DEBOUNCE_CYCLES+3 rising edges after the first edge that samples raw high.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
  - A held button produces exactly one pulse.
  - Release produces no pulse.
- FSM states (encoded value on the state output):
  - LOAD_A=0: on enter pulse, A<=sw; go to LOAD_B.
  - LOAD_B=1: on enter pulse, B<=sw; go to SHOW.
  - SHOW=2: on enter pulse, result_valid<=0; go to LOAD_A. A and B keep their values until relatched.
  - Encoding 3 is illegal and recovers to LOAD_A on the next clock.
- Result capture:
  - On the first cycle in SHOW, result<=R and result_valid<=1.
  - While in SHOW, result<=R every cycle, so an op toggle is reflected one cycle later. result_valid stays 1 throughout.
- Op pulse: button<=~button in any state. It never changes state.
- Simultaneous enter and op pulses: both take effect in the same cycle. A capture on entering SHOW therefore uses the new button value.
- Arithmetic: result is R unchanged, modulo 2^WIDTH with no carry or overflow flag. Subtraction is two's complement A-B.
- sw is sampled only on the enter pulse cycle; sw changes at other times are ignored.

Decomposition:
- Shared header calc_defs.vh holds:
  - state localparams LOAD_A, LOAD_B, SHOW;
  - OP_ADD=0 and OP_SUB=1.
- Sub-module debounce_pulse (parameters DEBOUNCE_CYCLES and CNT_W; ports clk, reset, raw, level, rise) is instantiated twice.
- The top level holds the FSM, the operand registers and the result register.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Bounce rejection: btn_enter high for 3 cycles, low, high for 2 cycles, low -> no pulse, state stays 0, A=0. Then hold high for 20 cycles -> exactly one enter pulse at DEBOUNCE_CYCLES+3 edges, state=1.
- Add path: sw=10, press enter; sw=15, press enter -> A=10, B=15, button=0, state=2. One cycle after reaching SHOW: result=9 (25 mod 16), result_valid=1.
- Op toggle in SHOW: press op -> button=1 and result=11 (10-15 mod 16) one cycle later. result_valid stays 1 and state stays 2.
- Wrap to next operation: press enter -> state=0, result_valid=0. sw=1, enter; sw=4, enter with button still 1 -> result=13 (1-4 mod 16).
- Simultaneous events: in LOAD_B with sw=3 and A=5, enter and op pulses land on the same cycle -> B=3, button flips to 0, state=2, next cycle result=8.
- Reset mid-operation: assert reset asynchronously (between clock edges) while in LOAD_B with A=7 -> immediately A=0, B=0, button=0, result=0, result_valid=0, state=0. After release, a held button still produces exactly one pulse.

Source files
------------

// File: rtl/calc_input_controller_pkg.sv
// -----------------------------------------------------------------------------
// calc_input_controller_pkg
// Shared definitions for the calculator input controller.
//   state_t : FSM state encoding. These values appear directly on the state
//             output that drives the LEDs.
//   OP_ADD / OP_SUB : encoding of the operation-select line to adder_subtractor.
// -----------------------------------------------------------------------------
package calc_input_controller_pkg;

  // Encoding 2'd3 is unused. The FSM recovers from it to LOAD_A.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SHOW   = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Synchronises one raw pushbutton and debounces it. It produces a one-cycle
// pulse on every debounced press.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   raw   : raw, asynchronous, bouncy button input
//   level : debounced button level
//   rise  : registered pulse, high for one cycle after level goes 0->1
// Latency from the first edge that samples raw high to the rise pulse is
// DEBOUNCE_CYCLES+3 edges:
//   - 2 edges for the synchroniser,
//   - DEBOUNCE_CYCLES edges for the stability count,
//   - 1 edge for the rise register.
// -----------------------------------------------------------------------------
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register below is updated with non-blocking assignments, so
  // each flop samples the pre-edge value of its source. A blocking assignment
  // here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      rise    <= level & ~level_q;

      // The counter measures how long the synchronised input has disagreed
      // with the debounced level. Any agreement restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_input_controller.sv
// -----------------------------------------------------------------------------
// calc_input_controller
// Front end for adder_subtractor. Enter presses latch the switches into A,
// then into B, then show the result. Op presses toggle add/subtract.
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   sw           : raw switch value, sampled only on an enter pulse
//   btn_enter    : raw enter pushbutton
//   btn_op       : raw op pushbutton
//   A, B         : operands to adder_subtractor
//   button       : operation select (0 = add, 1 = subtract)
//   R            : combinational result from adder_subtractor
//   result       : captured result
//   result_valid : high while result matches the current A, B, button
//   state        : current FSM state (LOAD_A=0, LOAD_B=1, SHOW=2)
// -----------------------------------------------------------------------------
module calc_input_controller
  import calc_input_controller_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             button,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       state
);

  logic   enter_level;
  logic   enter_rise;
  logic   op_level;
  logic   op_rise;
  state_t cur;

  // The debounced levels are not needed here. Only the press pulses are used.
  logic unused_level;
  assign unused_level = &{1'b0, enter_level, op_level};

  debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_enter (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_enter),
    .level (enter_level),
    .rise  (enter_rise)
  );

  debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_op (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_op),
    .level (op_level),
    .rise  (op_rise)
  );

  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= LOAD_A;
      A            <= '0;
      B            <= '0;
      button       <= OP_ADD;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      // An op press flips the operation in any state. It is independent of
      // the enter handling, so simultaneous pulses both take effect.
      if (op_rise) begin
        button <= ~button;
      end

      case (cur)
        LOAD_A: begin
          if (enter_rise) begin
            A   <= sw;
            cur <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_rise) begin
            B   <= sw;
            cur <= SHOW;
          end
        end
        SHOW: begin
          // R is recaptured every cycle, so an op toggle shows up one cycle
          // after button changes.
          result <= R;
          if (enter_rise) begin
            result_valid <= 1'b0;
            cur          <= LOAD_A;
          end else begin
            result_valid <= 1'b1;
          end
        end
        default: cur <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_input_controller.sv
// -----------------------------------------------------------------------------
// tb_calc_input_controller
// Bench for calc_input_controller with DEBOUNCE_CYCLES=4. A behavioural
// adder_subtractor drives R. Expected results are queued when the second
// operand is entered. They are compared when result_valid rises.
// -----------------------------------------------------------------------------
module tb_calc_input_controller;

  localparam int WIDTH = 4;
  localparam int DC    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sw;
  logic             btn_enter;
  logic             btn_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             button;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [1:0]       state;

  int total = 0;
  int bad   = 0;

  calc_input_controller #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (18)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btn_op       (btn_op),
    .A            (A),
    .B            (B),
    .button       (button),
    .R            (R),
    .result       (result),
    .result_valid (result_valid),
    .state        (state)
  );

  // Behavioural adder_subtractor: result is modulo 2^WIDTH.
  assign R = button ? WIDTH'(A - B) : WIDTH'(A + B);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge counter and enter-pulse monitor. The pulse is sampled on the falling edge.
  int cyc = 0;
  int enter_pulses = 0;
  int pulse_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (u_dut.u_enter.rise) begin
      enter_pulses++;
      pulse_cyc = cyc;
    end
  end

  // Scoreboard: expected results are popped when result_valid rises.
  logic [WIDTH-1:0] sb_q[$];
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'(result), 32'hFFFF);
      end else begin
        check("sb_result", 32'(result), 32'(sb_q.pop_front()));
      end
    end
    prev_valid = result_valid;
  end

  task automatic press(input logic en, input logic op);
    btn_enter = en;
    btn_op    = op;
    repeat (12) tick();
    btn_enter = 1'b0;
    btn_op    = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n = 0;
    while (state != s && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             exp_button;
    logic [WIDTH-1:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int start;
    int n;

    vecs[0] = '{a: 4'd7,  b: 4'd3,  op: 1'b1, exp_button: 1'b1, exp_res: 4'd4};
    vecs[1] = '{a: 4'd1,  b: 4'd4,  op: 1'b0, exp_button: 1'b1, exp_res: 4'd13};
    vecs[2] = '{a: 4'd0,  b: 4'd1,  op: 1'b1, exp_button: 1'b0, exp_res: 4'd1};
    vecs[3] = '{a: 4'd15, b: 4'd15, op: 1'b0, exp_button: 1'b0, exp_res: 4'd14};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  op: 1'b1, exp_button: 1'b1, exp_res: 4'd0};
    vecs[5] = '{a: 4'd10, b: 4'd15, op: 1'b1, exp_button: 1'b0, exp_res: 4'd9};

    reset = 1'b1; sw = '0; btn_enter = 1'b0; btn_op = 1'b0;
    repeat (3) tick();
    check("rst_A", 32'(A), 0);
    check("rst_B", 32'(B), 0);
    check("rst_button", 32'(button), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_state", 32'(state), 0);
    reset = 1'b0;
    tick();

    // Bounce rejection: raw high for 3 cycles, then for 2 cycles.
    sw = 4'd6;
    btn_enter = 1'b1; repeat (3) tick();
    btn_enter = 1'b0; repeat (2) tick();
    btn_enter = 1'b1; repeat (2) tick();
    btn_enter = 1'b0; repeat (12) tick();
    check("bounce_pulses", 32'(enter_pulses), 0);
    check("bounce_state", 32'(state), 0);
    check("bounce_A", 32'(A), 0);

    // A held press gives exactly one pulse, DC+3 edges after the first high sample.
    start = cyc;
    btn_enter = 1'b1; repeat (20) tick();
    check("hold_pulses", 32'(enter_pulses), 1);
    check("hold_latency", 32'(pulse_cyc - start), 32'(DC + 3));
    check("hold_state", 32'(state), 1);
    check("hold_A", 32'(A), 6);
    btn_enter = 1'b0; repeat (12) tick();
    check("release_pulses", 32'(enter_pulses), 1);

    // Finish this operation (B=0): 6+0=6. Then return to LOAD_A.
    sw = 4'd0;
    sb_q.push_back(4'd6);
    press(1'b1, 1'b0);
    check("first_show_state", 32'(state), 2);
    press(1'b1, 1'b0);
    check("first_wrap_state", 32'(state), 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].op) begin
        press(1'b0, 1'b1);
        check("vec_op_state", 32'(state), 0);
      end
      check("vec_button", 32'(button), 32'(vecs[i].exp_button));
      sw = vecs[i].a;
      press(1'b1, 1'b0);
      check("vec_A", 32'(A), 32'(vecs[i].a));
      check("vec_state_b", 32'(state), 1);
      sw = vecs[i].b;
      sb_q.push_back(vecs[i].exp_res);
      press(1'b1, 1'b0);
      check("vec_B", 32'(B), 32'(vecs[i].b));
      check("vec_state_show", 32'(state), 2);
      check("vec_valid", 32'(result_valid), 1);
      check("vec_result", 32'(result), 32'(vecs[i].exp_res));
      if (i < 5) begin
        press(1'b1, 1'b0);
        check("vec_wrap_state", 32'(state), 0);
        check("vec_wrap_valid", 32'(result_valid), 0);
      end
    end

    // Op toggle in SHOW: result follows one cycle after button flips.
    btn_op = 1'b1;
    n = 0;
    while (button != 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("show_op_button", 32'(button), 1);
    check("show_op_result_old", 32'(result), 9);
    tick();
    check("show_op_result_new", 32'(result), 11);
    check("show_op_valid", 32'(result_valid), 1);
    check("show_op_state", 32'(state), 2);
    btn_op = 1'b0; repeat (12) tick();

    // Wrap to the next operation: subtract 1-4.
    press(1'b1, 1'b0);
    check("wrap_state", 32'(state), 0);
    check("wrap_valid", 32'(result_valid), 0);
    sw = 4'd1; press(1'b1, 1'b0);
    sw = 4'd4; sb_q.push_back(4'd13); press(1'b1, 1'b0);
    check("wrap_result", 32'(result), 13);

    // Simultaneous enter and op in LOAD_B: A=5, B=3, button 1->0.
    press(1'b1, 1'b0);
    sw = 4'd5; press(1'b1, 1'b0);
    check("sim_A", 32'(A), 5);
    sw = 4'd3;
    sb_q.push_back(4'd8);
    btn_enter = 1'b1; btn_op = 1'b1;
    wait_state(2'd2, "sim_state");
    check("sim_button_same_cycle", 32'(button), 0);
    check("sim_B", 32'(B), 3);
    tick();
    check("sim_result", 32'(result), 8);
    btn_enter = 1'b0; btn_op = 1'b0; repeat (12) tick();

    // Asynchronous reset in the middle of a cycle while in LOAD_B.
    press(1'b1, 1'b0);
    sw = 4'd7; press(1'b1, 1'b0);
    check("pre_rst_A", 32'(A), 7);
    check("pre_rst_state", 32'(state), 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_A", 32'(A), 0);
    check("arst_B", 32'(B), 0);
    check("arst_button", 32'(button), 0);
    check("arst_result", 32'(result), 0);
    check("arst_valid", 32'(result_valid), 0);
    check("arst_state", 32'(state), 0);
    tick();
    reset = 1'b0;
    tick();
    enter_pulses = 0;
    sw = 4'd9;
    btn_enter = 1'b1; repeat (20) tick();
    check("post_rst_pulses", 32'(enter_pulses), 1);
    check("post_rst_state", 32'(state), 1);
    check("post_rst_A", 32'(A), 9);
    btn_enter = 1'b0; repeat (12) tick();

    check("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
